spi_reg_master: RTL

//  SPI initiator for the team's SPI register slaves (2-bit address, 8-bit registers).

---
 rtl/spi_reg_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 initiator issuing 16-bit register frames
// Frame: {rw, addr zero-extended to 7 bits, wdata or zeros on read}, MSB first.
module spi_reg_master #(
   parameter int CLK_DIV  = 4,
   parameter int ADDR_W   = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic              busy,
   output logic              done,
   output logic [7:0]        rdata,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs
);

   localparam int MAX_SU  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_HG  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
   localparam int MAX_CNT = (MAX_SU > MAX_HG) ? MAX_SU : MAX_HG;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [14:0]      shreg, shreg_n;
   logic [7:0]       rx, rx_n;
   logic             rw_q, rw_n;
   logic [7:0]       rdata_n;
   logic             done_n, sclk_n, cs_n, mosi_n;
   logic [15:0]      frame;

   assign frame = {rw, 7'(addr), rw ? wdata : 8'h00};
   assign busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         rx      <= '0;
         rw_q    <= 1'b0;
         rdata   <= 8'h00;
         done    <= 1'b0;
         sclk    <= 1'b0;
         cs      <= 1'b1;
         mosi    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         rx      <= rx_n;
         rw_q    <= rw_n;
         rdata   <= rdata_n;
         done    <= done_n;
         sclk    <= sclk_n;
         cs      <= cs_n;
         mosi    <= mosi_n;
      end
   end

   // Pins are registered: next values are computed here so sclk/cs/mosi never glitch.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      rx_n      = rx;
      rw_n      = rw_q;
      rdata_n   = rdata;
      done_n    = 1'b0;
      sclk_n    = sclk;
      cs_n      = cs;
      mosi_n    = mosi;
      case (state)
         IDLE: begin
            if (start) begin
               shreg_n   = frame[14:0];
               mosi_n    = frame[15];
               rw_n      = rw;
               cnt_n     = '0;
               bit_cnt_n = '0;
               rx_n      = '0;
               cs_n      = 1'b0;
               sclk_n    = 1'b0;
               state_n   = SETUP;
            end
         end
         SETUP: begin
            if (cnt == SETUP_LAST) begin
               cnt_n   = '0;
               state_n = SHIFT;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt != DIV_LAST) begin
               cnt_n = cnt + 1'b1;
            end else if (!sclk) begin
               cnt_n  = '0;
               sclk_n = 1'b1;
            end else begin
               // Last high-phase cycle: sample miso, drop sclk and present the next bit.
               cnt_n  = '0;
               sclk_n = 1'b0;
               if (bit_cnt[3]) begin
                  rx_n = {rx[6:0], miso};
               end
               if (bit_cnt == 4'd15) begin
                  mosi_n  = 1'b0;
                  state_n = HOLD;
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
                  mosi_n    = shreg[14];
                  shreg_n   = {shreg[13:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (cnt == HOLD_LAST) begin
               cnt_n   = '0;
               cs_n    = 1'b1;
               state_n = GAP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n   = '0;
               done_n  = 1'b1;
               state_n = IDLE;
               if (!rw_q) begin
                  rdata_n = rx;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cs_n    = 1'b1;
            sclk_n  = 1'b0;
            mosi_n  = 1'b0;
         end
      endcase
   end

endmodule
